// File: rtl/sos_coef_loader_pkg.sv
// Shared types and constants for the SOS coefficient loader (package sos_pkg).
package sos_pkg;

  localparam int TAPSIZE = 3;
  localparam int WI      = 5;
  localparam int WF      = 11;
  localparam int CW      = WI + WF;
  localparam int NCOEF   = 2 * TAPSIZE;
  localparam int IW      = $clog2(NCOEF);

  localparam logic [CW-1:0] ONE_Q = CW'(1) << WF;

  // Word order b0..b(T-1), a0..a(T-1); index 0 sits in the LSBs.
  typedef logic [NCOEF-1:0][CW-1:0] coef_bank_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, PEND} load_state_e;

  // Pass-through filter: b0 = a0 = 1.0, everything else zero.
  function automatic coef_bank_t coefResetBank();
    coef_bank_t bank;
    bank          = '0;
    bank[0]       = ONE_Q;
    bank[TAPSIZE] = ONE_Q;
    return bank;
  endfunction

  localparam coef_bank_t COEF_RST = coefResetBank();

endpackage

// File: rtl/sos_coef_loader_if.sv
// Word-serial valid/ready configuration stream feeding the coefficient loader.
interface sos_coef_loader_if;
  import sos_pkg::*;

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_data;
  logic          cfg_last;

  modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);

endinterface

// File: rtl/sos_coef_loader_bank.sv
// Shadow/active coefficient register pair: indexed shadow writes, atomic copy to active.
module sos_coef_bank
  import sos_pkg::*;
(
  input  logic          CLK,
  input  logic          nReset,
  input  logic          wrEn_i,
  input  logic [IW-1:0] wrIdx_i,
  input  logic [CW-1:0] wrData_i,
  input  logic          copy_i,
  output coef_bank_t    active_o
);

  coef_bank_t shadow_q;
  coef_bank_t active_q;

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      shadow_q <= '0;
    end else if (wrEn_i && (wrIdx_i < IW'(NCOEF))) begin
      shadow_q[wrIdx_i] <= wrData_i;
    end
  end

  // The whole bank moves in one edge so the filter never sees a mixed set.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      active_q <= COEF_RST;
    end else if (copy_i) begin
      active_q <= shadow_q;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/sos_coef_loader.sv
// SOS coefficient loader: framing FSM plus shadow/active bank, swapped on sample_tick.
// Optional readback port enabled by defining SOS_COEF_READBACK_EN.
module sos_coef_loader
  import sos_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nReset,
  input  logic                  CE,
  sos_coef_loader_if.slave      cfg,
  input  logic                  sample_tick,
  output logic [TAPSIZE*CW-1:0] coef_b,
  output logic [TAPSIZE*CW-1:0] coef_a,
  output logic                  coef_upd,
  output logic                  pending,
  output logic                  frm_err
`ifdef SOS_COEF_READBACK_EN
  ,
  input  logic [IW-1:0]         rd_addr,
  output logic [CW-1:0]         rd_data
`endif
);

  load_state_e   state_q, state_d;
  logic [IW-1:0] wordIdx_q, wordIdx_d;
  logic          frmErr_q, frmErr_d;
  logic          coefUpd_q;
  logic          accept, tickEn, lastWord;
  logic          wrEn, copy;
  coef_bank_t    active;

  assign cfg.cfg_ready = nReset & CE & (state_q != PEND);
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;
  assign tickEn        = sample_tick & CE;
  assign lastWord      = (wordIdx_q == IW'(NCOEF - 1));

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      wordIdx_q <= '0;
      frmErr_q  <= 1'b0;
      coefUpd_q <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      wordIdx_q <= wordIdx_d;
      frmErr_q  <= frmErr_d;
      coefUpd_q <= copy;
    end
  end

  always_comb begin
    state_d   = state_q;
    wordIdx_d = wordIdx_q;
    frmErr_d  = frmErr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cfg.cfg_last) begin
            frmErr_d = 1'b1;
          end else begin
            state_d   = LOAD;
            wordIdx_d = IW'(1);
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wordIdx_d = wordIdx_q + 1'b1;
          if (lastWord) begin
            wordIdx_d = '0;
            if (cfg.cfg_last) begin
              state_d = PEND;
            end else begin
              frmErr_d = 1'b1;
              state_d  = DRAIN;
            end
          end else if (cfg.cfg_last) begin
            // Short frame: abandon the shadow contents, active bank stays put.
            frmErr_d  = 1'b1;
            wordIdx_d = '0;
            state_d   = IDLE;
          end
        end
      end
      DRAIN: begin
        if (accept && cfg.cfg_last) begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (tickEn) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrEn    = 1'b0;
    copy    = 1'b0;
    pending = 1'b0;
    case (state_q)
      IDLE:    wrEn = accept & ~cfg.cfg_last;
      LOAD:    wrEn = accept;
      PEND: begin
        pending = 1'b1;
        copy    = tickEn;
      end
      default: ;
    endcase
  end

  sos_coef_bank u_bank (
    .CLK      (CLK),
    .nReset   (nReset),
    .wrEn_i   (wrEn),
    .wrIdx_i  (wordIdx_q),
    .wrData_i (cfg.cfg_data),
    .copy_i   (copy),
    .active_o (active)
  );

  assign coef_b   = active[TAPSIZE-1:0];
  assign coef_a   = active[NCOEF-1:TAPSIZE];
  assign coef_upd = coefUpd_q;
  assign frm_err  = frmErr_q;

`ifdef SOS_COEF_READBACK_EN
  logic [CW-1:0] rdData_q;

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      rdData_q <= '0;
    end else if (CE) begin
      rdData_q <= (rd_addr < IW'(NCOEF)) ? active[rd_addr] : '0;
    end
  end

  assign rd_data = rdData_q;
`endif

endmodule

// File: doc/sos_coef_loader.md
Name: sos_coef_loader

Overview:
Loads the six second-order-section coefficients (b0,b1,b2,a0,a1,a2) from a word-serial valid/ready configuration stream into a shadow bank. The shadow bank is copied atomically into the active bank that drives the SOS filter's coefficient inputs. The swap happens only on a sample boundary, so the filter never computes a sample with a mix of old and new coefficients. The block sits between the host/config bus and the sos filter instance.

Parameters:
TAPSIZE, 3, taps per direction; frame length is 2*TAPSIZE words.
WI, 5, coefficient integer bits (sign included).
WF, 11, coefficient fraction bits; coefficient width CW = WI+WF.

Ports:
CLK  in  1  system clock, rising edge.
nReset  in  1  asynchronous active-low reset.
CE  in  1  active-high clock enable; all state advances qualified by CE.
cfg_valid  in  1  config word valid.
cfg_ready  out  1  loader can accept a word.
cfg_data  in  CW  signed coefficient word, Q(WI.WF).
cfg_last  in  1  marks final word of a frame.
sample_tick  in  1  filter sample boundary, one-cycle pulse.
coef_b  out  TAPSIZE*CW  active b bank; b0 in LSBs.
coef_a  out  TAPSIZE*CW  active a bank; a0 in LSBs.
coef_upd  out  1  one-cycle pulse when the active bank changes.
pending  out  1  a complete frame is waiting for sample_tick.
frm_err  out  1  sticky framing error; cleared only by reset.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (CLK, nReset).
- Reset values:
  - active b0 = a0 = 1.0 (1<<WF); all other active coefficients 0 (pass-through).
  - shadow bank all 0; state IDLE; word counter 0.
  - cfg_ready=0 during reset; coef_upd=0, pending=0, frm_err=0.
- Accepted transfer: cfg_valid & cfg_ready & CE. Word order is b0,b1,b2,a0,a1,a2; the counter idx indexes the shadow bank.
- FSM states: IDLE, LOAD, DRAIN, PEND.
  - IDLE: cfg_ready=CE. On an accepted word, write shadow[0], idx=1, go to LOAD. If that word already has cfg_last=1 (and 2*TAPSIZE>1): set frm_err, discard, stay in IDLE.
  - LOAD: cfg_ready=CE. Each accepted word writes shadow[idx], idx++.
    - Word idx=2*TAPSIZE-1 with cfg_last=1: go to PEND.
    - Same word with cfg_last=0: set frm_err, go to DRAIN.
    - cfg_last=1 on any earlier word: set frm_err, go to IDLE; the shadow bank is invalid but the active bank is untouched.
  - DRAIN: cfg_ready=CE. Accept and discard words until one with cfg_last=1, then go to IDLE. The shadow bank is not written.
  - PEND: cfg_ready=0, pending=1. On sample_tick & CE: copy all 2*TAPSIZE shadow words to active, coef_upd=1 for that cycle, go to IDLE.
- Latency:
  - Active outputs update on the clock edge that samples sample_tick in PEND.
  - A tick coincident with the final accepted word does not swap; the swap waits for the next tick.
- Clock enable: with CE=0, no transfers, no swap, and outputs hold.
- Outputs coef_b/coef_a are registered, never combinational from cfg_data.
- Reset mid-frame: partial frame discarded; active bank returns to reset defaults.
- No arithmetic. Coefficients are stored bit-exact; no saturation or rescaling.

Optional Feature:
- Macro: SOS_COEF_READBACK_EN.
- Defined: adds input rd_addr [$clog2(2*TAPSIZE)-1:0] and output rd_data [CW-1:0].
  - rd_data is registered, one cycle after rd_addr, and reads the active bank in word-order indexing.
  - Addresses >= 2*TAPSIZE return 0. Reset value of rd_data is 0.
- Not defined: both ports absent; no readback logic.

Decomposition:
- Shared package sos_pkg:
  - CW, NCOEF=2*TAPSIZE.
  - ONE_Q = 1<<WF.
  - Reset coefficient defaults.
  - FSM state enum (IDLE, LOAD, DRAIN, PEND).
- One natural sub-module: sos_coef_bank. It holds the shadow/active register pair with write-enable/index and a copy strobe; the FSM stays in sos_coef_loader.

Test Plan:
- Reset: assert nReset=0 mid-run -> coef_b LSW=0x0800 (WF=11), coef_a LSW=0x0800, all else 0; cfg_ready=0 during reset; pending=0, frm_err=0.
- Nominal load: send 0x0400,0x0800,0x0400,0x0800,0xF000,0x0200 with cfg_last on word 6; pending=1, actives unchanged; sample_tick -> next edge coef_b={0x0400,0x0800,0x0400}, coef_a={0x0200,0xF000,0x0800} (MSB..LSB), coef_upd pulses once.
- Early last: cfg_last on word 3 -> frm_err=1, state IDLE, active bank unchanged, no coef_upd on later ticks.
- Missing last: 6 words without last, then 2 extra words with last on the 2nd -> frm_err=1, all 8 accepted (cfg_ready high), active bank unchanged.
- Backpressure and tick: tick coincident with word 6 -> no swap; cfg_valid held in PEND sees cfg_ready=0; next tick swaps and cfg_ready reasserts the following cycle.
- CE gating: CE=0 with cfg_valid=1 and sample_tick pulses -> no transfers, no swap; resume with CE=1 completes the frame normally.
